// File: rtl/bus1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus1_pkg
//  Description : Shared widths, command/response codes and FSM state codes
//                for the bus-1 cache responder and its byte store.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus1_pkg;

    localparam int ADDR1_BUS_SIZE    = 15;
    localparam int DATA1_BUS_SIZE    = 16;
    localparam int CTR1_BUS_SIZE     = 3;
    localparam int CACHE_OFFSET_SIZE = 4;

    // Full byte address as seen by the store: {tagset, offset}.
    localparam int STORE_ADDR_W = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;

    // Initiator command codes.
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_NOP             = 3'd0;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ8           = 3'd1;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ16          = 3'd2;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32          = 3'd3;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_INVALIDATE_LINE = 3'd4;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE8          = 3'd5;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE16         = 3'd6;
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE32         = 3'd7;

    // Responder-to-initiator code (shares the WRITE32 encoding).
    localparam logic [CTR1_BUS_SIZE-1:0] RSP_RESPONSE        = 3'd7;

    // Responder FSM states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR2 = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP1 = 3'd3;
    localparam logic [2:0] ST_RESP2 = 3'd4;

    function automatic logic cmd_is_read(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return (cmd == CMD_READ8) || (cmd == CMD_READ16) || (cmd == CMD_READ32);
    endfunction

    function automatic logic cmd_is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
        return (cmd == CMD_WRITE8) || (cmd == CMD_WRITE16) || (cmd == CMD_WRITE32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus1_byte_store.sv
`default_nettype none
// ============================================================================
//  Module      : bus1_byte_store
//  Description : MEM_BYTES x 8 local store. One asynchronous 4-byte read port
//                and one byte-enabled 4-byte write port sharing one address.
//                Lane i addresses byte (offset + i) mod 16 of the same 16-byte
//                line, so multi-byte accesses wrap inside the line.
//  Ports       : clk   - clock
//                addr  - {tagset, offset}; only the low log2(MEM_BYTES) bits used
//                we    - write strobe, be - per-lane byte enables
//                wdata - lane i in bits [8i+7:8i]
//                rdata - lane i in bits [8i+7:8i]
//  Revision    : 1.0 - initial release
// ============================================================================
module bus1_byte_store
    import bus1_pkg::*;
#(
    parameter int MEM_BYTES = 512
) (
    input  logic                    clk,
    input  logic [STORE_ADDR_W-1:0] addr,
    input  logic                    we,
    input  logic [3:0]              be,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_lane_addr [4];

    assign w_base = addr[AW-1:0];

    // Keep the line bits of the address, replace the low nibble with the
    // wrapped per-lane offset.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_lane_addr[i] = (w_base & ~AW'(15)) | AW'(4'(w_base[3:0] + 4'(i)));
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rdata[gi*8 +: 8] = r_mem[w_lane_addr[gi]];
        end
    endgenerate

    // The store deliberately has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                r_mem[w_lane_addr[i]] <= wdata[i*8 +: 8];
            end
        end
    end

    // Tagset bits above the store size alias onto the same bytes.
    generate
        if (AW < STORE_ADDR_W) begin : g_addr_alias
            logic w_unused_high_addr;
            assign w_unused_high_addr = ^addr[STORE_ADDR_W-1:AW];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cache_bus1_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cache_bus1_responder
//  Description : Bus-1 target. Captures a two-cycle request (tag+set, then
//                offset/high data), waits RESP_LATENCY idle cycles and
//                answers with RESPONSE. Reads return data from the local
//                byte store; writes commit on entry to the first response
//                cycle. INVALIDATE_LINE is a one-cycle request with a
//                data-less response.
//  Ports       : clk, rst_n (synchronous, active-low)
//                a1_in/d1_in/c1_in  - request address, write data, command
//                d1_out/d1_oe       - read data and its drive enable
//                c1_out/c1_oe       - response code and its drive enable
//                busy               - transaction in progress
//                err                - non-NOP command seen while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_bus1_responder
    import bus1_pkg::*;
#(
    parameter int RESP_LATENCY = 4,
    parameter int MEM_BYTES    = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR1_BUS_SIZE-1:0] a1_in,
    input  logic [DATA1_BUS_SIZE-1:0] d1_in,
    input  logic [CTR1_BUS_SIZE-1:0]  c1_in,
    output logic [DATA1_BUS_SIZE-1:0] d1_out,
    output logic                      d1_oe,
    output logic [CTR1_BUS_SIZE-1:0]  c1_out,
    output logic                      c1_oe,
    output logic                      busy,
    output logic                      err
);

    // Last WAIT count value and the state that follows the address phase.
    localparam logic [3:0] c_last_wait  = 4'((RESP_LATENCY > 0) ? RESP_LATENCY - 1 : 0);
    localparam logic [2:0] c_after_addr = (RESP_LATENCY == 0) ? ST_RESP1 : ST_WAIT;

    logic [2:0]                   r_state;
    logic [2:0]                   w_next_state;
    logic [CTR1_BUS_SIZE-1:0]     r_cmd;
    logic [ADDR1_BUS_SIZE-1:0]    r_tagset;
    logic [CACHE_OFFSET_SIZE-1:0] r_offset;
    logic [DATA1_BUS_SIZE-1:0]    r_data_lo;
    logic [DATA1_BUS_SIZE-1:0]    r_data_hi;
    logic [3:0]                   r_count;

    logic [CACHE_OFFSET_SIZE-1:0] w_offset;
    logic [DATA1_BUS_SIZE-1:0]    w_data_hi;
    logic                         w_commit;
    logic [3:0]                   w_be;
    logic [31:0]                  w_rdata;
    logic                         w_resp;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (c1_in == CMD_INVALIDATE_LINE) begin
                    w_next_state = c_after_addr;
                end else if (c1_in != CMD_NOP) begin
                    w_next_state = ST_ADDR2;
                end
            end
            ST_ADDR2: w_next_state = c_after_addr;
            ST_WAIT: begin
                if (r_count == c_last_wait) begin
                    w_next_state = ST_RESP1;
                end
            end
            ST_RESP1: w_next_state = (r_cmd == CMD_READ32) ? ST_RESP2 : ST_IDLE;
            ST_RESP2: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_cmd     <= CMD_NOP;
            r_tagset  <= '0;
            r_offset  <= '0;
            r_data_lo <= '0;
            r_data_hi <= '0;
        end else begin
            r_state <= w_next_state;
            // Counter is zero whenever WAIT is entered.
            r_count <= (r_state == ST_WAIT) ? r_count + 4'd1 : 4'd0;
            if ((r_state == ST_IDLE) && (c1_in != CMD_NOP)) begin
                r_cmd     <= c1_in;
                r_tagset  <= a1_in;
                r_data_lo <= d1_in;
            end
            if (r_state == ST_ADDR2) begin
                r_offset  <= a1_in[CACHE_OFFSET_SIZE-1:0];
                r_data_hi <= d1_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store access. With zero latency the commit happens on the same edge
    // that closes the address phase, so offset and high data are taken
    // straight from the bus in ADDR2.
    // ------------------------------------------------------------------
    assign w_offset  = (r_state == ST_ADDR2) ? a1_in[CACHE_OFFSET_SIZE-1:0] : r_offset;
    assign w_data_hi = (r_state == ST_ADDR2) ? d1_in : r_data_hi;

    // IDLE->RESP1 is only taken by INVALIDATE_LINE, where r_cmd is stale.
    assign w_commit = rst_n && (r_state != ST_IDLE) && (w_next_state == ST_RESP1)
                      && cmd_is_write(r_cmd);

    always_comb begin
        w_be = 4'b0000;
        case (r_cmd)
            CMD_WRITE8:  w_be = 4'b0001;
            CMD_WRITE16: w_be = 4'b0011;
            CMD_WRITE32: w_be = 4'b1111;
            default:     w_be = 4'b0000;
        endcase
    end

    bus1_byte_store #(
        .MEM_BYTES (MEM_BYTES)
    ) u_store (
        .clk   (clk),
        .addr  ({r_tagset, w_offset}),
        .we    (w_commit),
        .be    (w_be),
        .wdata ({w_data_hi, r_data_lo}),
        .rdata (w_rdata)
    );

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign w_resp = (r_state == ST_RESP1) || (r_state == ST_RESP2);
    assign c1_oe  = w_resp;
    assign c1_out = w_resp ? RSP_RESPONSE : CMD_NOP;
    assign d1_oe  = w_resp && cmd_is_read(r_cmd);
    assign busy   = (r_state != ST_IDLE);
    assign err    = busy && (c1_in != CMD_NOP);

    always_comb begin
        d1_out = '0;
        if (d1_oe) begin
            case (r_cmd)
                CMD_READ8:  d1_out = {8'h00, w_rdata[7:0]};
                CMD_READ16: d1_out = w_rdata[15:0];
                CMD_READ32: d1_out = (r_state == ST_RESP2) ? w_rdata[31:16] : w_rdata[15:0];
                default:    d1_out = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_bus1_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_bus1_responder
//  Description : Self-checking bench. Unit 0 uses RESP_LATENCY=4, unit 1
//                uses RESP_LATENCY=0. A byte-array model of the store gives
//                expected read data; response timing comes from the request
//                timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_bus1_responder;

    localparam int MEM = 512;
    localparam logic [2:0] NOP = 3'd0, RD8 = 3'd1, RD16 = 3'd2, RD32 = 3'd3;
    localparam logic [2:0] INV = 3'd4, WR8 = 3'd5, WR16 = 3'd6, WR32 = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n  [2];
    logic [14:0] a1     [2];
    logic [15:0] d1     [2];
    logic [2:0]  c1     [2];
    logic [15:0] d1o    [2];
    logic        d1oe   [2];
    logic [2:0]  c1o    [2];
    logic        c1oe   [2];
    logic        busy_o [2];
    logic        err_o  [2];

    logic [7:0]  model [2][MEM];

    int vectors     = 0;
    int miscompares = 0;

    // Per-transaction observations.
    int          m_first, m_nresp, m_ndoe, m_nerr, m_err_cycle, m_bad, m_busy_end;
    logic        m_busy0;
    logic [15:0] m_w [2];

    always #5 clk = ~clk;

    cache_bus1_responder #(.RESP_LATENCY(4), .MEM_BYTES(MEM)) dut (
        .clk(clk), .rst_n(rst_n[0]), .a1_in(a1[0]), .d1_in(d1[0]), .c1_in(c1[0]),
        .d1_out(d1o[0]), .d1_oe(d1oe[0]), .c1_out(c1o[0]), .c1_oe(c1oe[0]),
        .busy(busy_o[0]), .err(err_o[0]));

    cache_bus1_responder #(.RESP_LATENCY(0), .MEM_BYTES(MEM)) dut0 (
        .clk(clk), .rst_n(rst_n[1]), .a1_in(a1[1]), .d1_in(d1[1]), .c1_in(c1[1]),
        .d1_out(d1o[1]), .d1_oe(d1oe[1]), .c1_out(c1o[1]), .c1_oe(c1oe[1]),
        .busy(busy_o[1]), .err(err_o[1]));

    function automatic int lat_of(input int u);
        return (u == 0) ? 4 : 0;
    endfunction

    function automatic int nbytes(input logic [2:0] cmd);
        case (cmd)
            RD8, WR8:   return 1;
            RD16, WR16: return 2;
            RD32, WR32: return 4;
            default:    return 0;
        endcase
    endfunction

    // Byte i of an access: same 16-byte line, offset wraps mod 16.
    function automatic int baddr(input logic [14:0] ts, input logic [3:0] off, input int i);
        int a;
        a = int'({ts, off}) % MEM;
        return (a - (a % 16)) + ((int'(off) + i) % 16);
    endfunction

    function automatic logic [15:0] model_half(input int u, input logic [14:0] ts,
                                               input logic [3:0] off, input int h);
        return {model[u][baddr(ts, off, 2*h+1)], model[u][baddr(ts, off, 2*h)]};
    endfunction

    function automatic logic [15:0] model_read(input int u, input logic [2:0] cmd,
                                               input logic [14:0] ts, input logic [3:0] off);
        if (cmd == RD8) return {8'h00, model[u][baddr(ts, off, 0)]};
        return model_half(u, ts, off, 0);
    endfunction

    // Drives one request on unit u and records what the responder does.
    // abort_cycle >= 0 asserts rst_n in that cycle and stops there.
    task automatic run_txn(input int u, input logic [2:0] cmd, input logic [14:0] ts,
                           input logic [3:0] off, input logic [31:0] wd,
                           input int inj_cycle, input logic [2:0] inj_cmd,
                           input int abort_cycle);
        int ncyc;
        ncyc = lat_of(u) + 7;
        m_first = -1; m_nresp = 0; m_ndoe = 0; m_nerr = 0; m_err_cycle = -1;
        m_bad = 0; m_busy_end = -1; m_busy0 = 1'b0; m_w[0] = '0; m_w[1] = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            c1[u] = NOP;
            a1[u] = 15'($urandom);
            d1[u] = 16'($urandom);
            if (k == 0) begin
                c1[u] = cmd; a1[u] = ts; d1[u] = wd[15:0];
            end else if (k == 1) begin
                a1[u][3:0] = off; d1[u] = wd[31:16];
            end
            if (k == inj_cycle) c1[u] = inj_cmd;
            if (k == abort_cycle) rst_n[u] = 1'b0;
            @(negedge clk);
            if (c1oe[u]) begin
                if (m_first < 0) m_first = k;
                if (m_nresp < 2) m_w[m_nresp] = d1o[u];
                m_nresp++;
            end
            if (c1o[u] !== (c1oe[u] ? 3'd7 : 3'd0)) m_bad++;
            if (d1oe[u]) m_ndoe++;
            if (d1oe[u] && !c1oe[u]) m_bad++;
            if (err_o[u]) begin m_nerr++; m_err_cycle = k; end
            if (k == 0) m_busy0 = busy_o[u];
            else if (!busy_o[u] && m_busy_end < 0) m_busy_end = k;
            if (k == abort_cycle) break;
        end
        if (abort_cycle < 0 && (cmd == WR8 || cmd == WR16 || cmd == WR32)) begin
            for (int i = 0; i < nbytes(cmd); i++) model[u][baddr(ts, off, i)] = wd[8*i +: 8];
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                rst_n[u] = 1'b0;
                c1[u] = (k == 2) ? NOP : RD8;
            end
            @(negedge clk);
            if (k == 0) continue;
            for (int u = 0; u < 2; u++) begin
                vectors++;
                if (d1o[u] !== 16'h0 || d1oe[u] !== 1'b0 || c1o[u] !== 3'd0 ||
                    c1oe[u] !== 1'b0 || busy_o[u] !== 1'b0 || err_o[u] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset u=%0d got d1=%h d1oe=%b c1=%0d c1oe=%b busy=%b err=%b want all zero",
                             u, d1o[u], d1oe[u], c1o[u], c1oe[u], busy_o[u], err_o[u]);
                end
            end
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    endtask

    // Gives every byte a known value in both stores.
    task automatic test_fill();
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < MEM; a += 4) begin
                run_txn(u, WR32, 15'(a >> 4), 4'(a % 16), $urandom, -1, NOP, -1);
                vectors++;
                if (m_nresp != 1 || m_ndoe != 0) begin
                    miscompares++;
                    $display("FAIL fill_resp u=%0d a=%0d got nresp=%0d ndoe=%0d want 1/0",
                             u, a, m_nresp, m_ndoe);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        run_txn(0, WR32, 15'h0002, 4'h4, 32'hDEADBEEF, -1, NOP, -1);
        run_txn(0, RD32, 15'h0002, 4'h4, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_first != 6 || m_nresp != 2 || m_ndoe != 2) begin
            miscompares++;
            $display("FAIL rd32_timing got first=%0d nresp=%0d ndoe=%0d want 6/2/2", m_first, m_nresp, m_ndoe);
        end
        vectors++;
        if (m_w[0] !== 16'hBEEF || m_w[1] !== 16'hDEAD) begin
            miscompares++;
            $display("FAIL rd32_data got %h %h want beef dead", m_w[0], m_w[1]);
        end
    endtask

    task automatic test_byte_ops();
        logic [15:0] exp16;
        run_txn(0, WR8, 15'h0002, 4'h5, 32'h000001A5, -1, NOP, -1);
        run_txn(0, RD8, 15'h0002, 4'h5, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== 16'h00A5 || m_nresp != 1 || m_ndoe != 1) begin
            miscompares++;
            $display("FAIL rd8_after_wr8 got d=%h nresp=%0d want 00a5/1", m_w[0], m_nresp);
        end
        exp16 = {8'hA5, model[0][9'h024]};
        run_txn(0, RD16, 15'h0002, 4'h4, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== exp16) begin
            miscompares++;
            $display("FAIL rd16_at_24 got %h want %h", m_w[0], exp16);
        end
    endtask

    task automatic test_line_wrap();
        run_txn(0, WR16, 15'h0001, 4'hF, 32'h00001234, -1, NOP, -1);
        run_txn(0, RD8, 15'h0001, 4'hF, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== 16'h0034) begin
            miscompares++;
            $display("FAIL wrap_lo got %h want 0034", m_w[0]);
        end
        run_txn(0, RD8, 15'h0001, 4'h0, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== 16'h0012) begin
            miscompares++;
            $display("FAIL wrap_hi got %h want 0012", m_w[0]);
        end
    endtask

    task automatic test_invalidate();
        logic [15:0] e0, e1;
        e0 = model_half(0, 15'h0002, 4'h4, 0);
        e1 = model_half(0, 15'h0002, 4'h4, 1);
        run_txn(0, INV, 15'h0002, 4'h4, 32'hFFFFFFFF, -1, NOP, -1);
        vectors++;
        if (m_first != 5 || m_nresp != 1 || m_ndoe != 0 || m_busy_end != 6) begin
            miscompares++;
            $display("FAIL inv_resp got first=%0d nresp=%0d ndoe=%0d busy_end=%0d want 5/1/0/6",
                     m_first, m_nresp, m_ndoe, m_busy_end);
        end
        run_txn(0, RD32, 15'h0002, 4'h4, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== e0 || m_w[1] !== e1) begin
            miscompares++;
            $display("FAIL inv_store got %h %h want %h %h", m_w[0], m_w[1], e0, e1);
        end
    endtask

    task automatic test_err_inject();
        logic [15:0] exp16;
        run_txn(0, WR16, 15'h0005, 4'h2, 32'h00007E81, 3, RD8, -1);
        vectors++;
        if (m_nerr != 1 || m_err_cycle != 3 || m_first != 6 || m_nresp != 1) begin
            miscompares++;
            $display("FAIL err_pulse got nerr=%0d at=%0d first=%0d nresp=%0d want 1/3/6/1",
                     m_nerr, m_err_cycle, m_first, m_nresp);
        end
        exp16 = model_half(0, 15'h0005, 4'h2, 0);
        run_txn(0, RD16, 15'h0005, 4'h2, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== exp16 || m_nerr != 0) begin
            miscompares++;
            $display("FAIL err_write got %h nerr=%0d want %h/0", m_w[0], m_nerr, exp16);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] old16;
        old16 = model_half(0, 15'h0003, 4'h6, 0);
        run_txn(0, WR16, 15'h0003, 4'h6, {16'h0, ~old16}, -1, NOP, 3);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (d1o[0] !== 16'h0 || d1oe[0] !== 1'b0 || c1o[0] !== 3'd0 ||
            c1oe[0] !== 1'b0 || busy_o[0] !== 1'b0 || err_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got d1=%h d1oe=%b c1=%0d c1oe=%b busy=%b err=%b want all zero",
                     d1o[0], d1oe[0], c1o[0], c1oe[0], busy_o[0], err_o[0]);
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        run_txn(0, RD16, 15'h0003, 4'h6, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_w[0] !== old16) begin
            miscompares++;
            $display("FAIL mid_reset_drop got %h want %h", m_w[0], old16);
        end
    endtask

    task automatic test_zero_latency();
        run_txn(1, WR32, 15'h0007, 4'hE, 32'hCAFE1234, -1, NOP, -1);
        vectors++;
        if (m_first != 2 || m_busy_end != 3) begin
            miscompares++;
            $display("FAIL z_wr_timing got first=%0d busy_end=%0d want 2/3", m_first, m_busy_end);
        end
        run_txn(1, RD32, 15'h0007, 4'hE, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_first != 2 || m_w[0] !== 16'h1234 || m_w[1] !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL z_rd32 got first=%0d %h %h want 2 1234 cafe", m_first, m_w[0], m_w[1]);
        end
        run_txn(1, INV, 15'h0007, 4'h0, 32'h0, -1, NOP, -1);
        vectors++;
        if (m_first != 1 || m_nresp != 1 || m_ndoe != 0) begin
            miscompares++;
            $display("FAIL z_inv got first=%0d nresp=%0d ndoe=%0d want 1/1/0", m_first, m_nresp, m_ndoe);
        end
    endtask

    task automatic test_random();
        int u, ef, en, ed, inj;
        logic [2:0] cmd, icmd;
        logic [14:0] ts;
        logic [3:0] off;
        logic [31:0] wd;
        logic [15:0] e0, e1;
        for (int n = 0; n < 80; n++) begin
            u    = n % 2;
            cmd  = 3'($urandom_range(1, 7));
            ts   = 15'($urandom);
            off  = 4'($urandom);
            wd   = $urandom;
            ef   = (cmd == INV) ? 1 + lat_of(u) : 2 + lat_of(u);
            en   = (cmd == RD32) ? 2 : 1;
            ed   = (cmd == RD8 || cmd == RD16 || cmd == RD32) ? en : 0;
            e0   = model_read(u, cmd, ts, off);
            e1   = model_half(u, ts, off, 1);
            inj  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ef)) : -1;
            icmd = 3'($urandom_range(1, 7));
            run_txn(u, cmd, ts, off, wd, inj, icmd, -1);
            vectors++;
            if (m_first != ef || m_nresp != en || m_ndoe != ed || m_busy_end != ef + en) begin
                miscompares++;
                $display("FAIL rnd_timing n=%0d cmd=%0d got first=%0d nresp=%0d ndoe=%0d busy_end=%0d want %0d/%0d/%0d/%0d",
                         n, cmd, m_first, m_nresp, m_ndoe, m_busy_end, ef, en, ed, ef + en);
            end
            vectors++;
            if (m_bad != 0 || m_busy0 !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_codes n=%0d got bad=%0d busy0=%b want 0/0", n, m_bad, m_busy0);
            end
            vectors++;
            if (m_nerr != ((inj >= 0) ? 1 : 0) || m_err_cycle != inj) begin
                miscompares++;
                $display("FAIL rnd_err n=%0d got nerr=%0d at=%0d want inj at %0d", n, m_nerr, m_err_cycle, inj);
            end
            if (ed > 0) begin
                vectors++;
                if (m_w[0] !== e0 || (cmd == RD32 && m_w[1] !== e1)) begin
                    miscompares++;
                    $display("FAIL rnd_data n=%0d cmd=%0d got %h %h want %h %h",
                             n, cmd, m_w[0], m_w[1], e0, e1);
                end
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; a1[u] = '0; d1[u] = '0; c1[u] = NOP;
        end
        test_reset();
        test_fill();
        test_word_rw();
        test_byte_ops();
        test_line_wrap();
        test_invalidate();
        test_err_inject();
        test_reset_mid();
        test_zero_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
